brc_nibble_seq: RTL and testbench
=================================

// Module: brc_nibble_seq
// PURPOSE
//  Multi-cycle branch comparator. It time-shares one 4-bit carry-lookahead nibble adder
//  to evaluate rs1 - rs2 (rs1 + ~rs2 + 1), least-significant nibble first, over XLEN/4 cycles.
//  It produces BrEq/BrLt flags for the branch unit in area-constrained builds.
//  It sits between the operand-read stage and branch resolution, with valid/ready on both sides.
// PARAMETERS
//  XLEN  32  operand width; multiple of 4, >= 8; NIBS = XLEN/4 = latency in RUN cycles
// PORTS
//  i_clk         in   1     clock, rising edge
//  i_rst         in   1     asynchronous, active-high reset
//  i_valid       in   1     operands valid (request)
//  o_ready       out  1     block can accept request (high only in IDLE)
//  i_rs1_data    in   XLEN  operand A
//  i_rs2_data    in   XLEN  operand B
//  i_br_un       in   1     1 = unsigned compare, 0 = signed compare
//  i_flush       in   1     synchronous abort of in-flight compare
//  o_valid       out  1     result valid (high only in DONE)
//  i_ready       in   1     consumer accepts result
//  o_br_equal    out  1     rs1 == rs2
//  o_br_less     out  1     rs1 < rs2 (per i_br_un captured at accept)
//  o_busy        out  1     state != IDLE
// BEHAVIOUR
//  - Reset (async, any state): state = IDLE, counter = 0, carry = 0, o_valid = 0.
//    Also o_br_equal = 0, o_br_less = 0, o_busy = 0, o_ready = 1 (combinational from IDLE).
//  - FSM states: IDLE -> RUN -> DONE -> IDLE.
//  - IDLE: o_ready = 1. On i_valid & o_ready at an edge, capture rs1, ~rs2 and i_br_un.
//    Also capture both operand MSBs, set carry = 1, set eq_acc = 1 and counter = 0, then go to RUN.
//  - RUN: each cycle, feed nibble[counter] of the captured A and ~B plus the carry register
//    to the CLA slice.
//    At the edge, carry <= Co and eq_acc <= eq_acc & (A_nib == B_nib), then counter++.
//    When counter == NIBS-1, go to DONE at that edge.
//    No request is accepted in RUN; i_valid is ignored (o_ready = 0).
//  - Flag rules, registered on the RUN -> DONE edge:
//    o_br_equal = final eq_acc.
//    Unsigned: o_br_less = ~carry_out (a borrow means A < B).
//    Signed: if MSB(A) != MSB(B), o_br_less = MSB(A); otherwise o_br_less = ~carry_out.
//  - Latency: request accepted at edge k, so o_valid = 1 after edge k+NIBS (8 for XLEN = 32).
//  - DONE: o_valid = 1. Flags are held stable while i_ready = 0, with no limit on hold time.
//    On i_ready, go to IDLE at that edge; o_valid drops and flags clear to 0.
//  - No overlap: a new request can be accepted no earlier than the edge after the result handshake.
//  - i_flush (RUN or DONE): go to IDLE at the next edge and discard the result.
//    o_valid is never asserted for a flushed compare.
//    i_flush in IDLE has priority over i_valid: nothing is accepted.
//  - Flush and i_ready both high in DONE: go to IDLE; the handshake counts as completed (same result).
//  - Counter width = $clog2(NIBS); the counter wraps to 0 on entry to RUN only.
//  - Reset mid-RUN: the partial result is lost. After release, the first accepted request
//    is computed from fresh operands.
// TESTING (XLEN = 32)
//  - rs1 = 0x00000005, rs2 = 0x00000005, un = 0 -> o_valid 8 cycles after accept, eq = 1, lt = 0.
//  - rs1 = 0xFFFFFFFF, rs2 = 0x00000001: un = 1 -> eq = 0, lt = 0; un = 0 -> lt = 1.
//  - rs1 = 0x80000000, rs2 = 0x7FFFFFFF: signed -> lt = 1; unsigned -> lt = 0.
//    rs1 = 0x0000FFF0, rs2 = 0x0001000F (carry across nibbles), un = 1 -> lt = 1.
//  - Hold i_ready = 0 for 5 cycles in DONE, with i_valid = 1 and new operands ->
//    flags and o_valid stable, o_ready = 0, new operands not captured.
//  - Assert i_rst asynchronously in RUN cycle 3 -> outputs go to reset values immediately.
//    After release o_ready = 1; the next compare 3 vs 7 unsigned -> lt = 1, eq = 0.
//  - i_flush in RUN cycle 4 -> IDLE next edge, o_valid never rises.
//    Back-to-back random compares (1000) match a reference model.

Source files
------------

// File: rtl/brc_nibble_seq.sv
// ============================================================================
// brc_nibble_seq : multi-cycle branch comparator, one 4-bit CLA slice over XLEN/4 cycles
// Revision 1.0
// ============================================================================
`default_nettype none

module brc_nibble_seq #(
    parameter int XLEN = 32
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_valid,
    output logic            o_ready,
    input  logic [XLEN-1:0] i_rs1_data,
    input  logic [XLEN-1:0] i_rs2_data,
    input  logic            i_br_un,
    input  logic            i_flush,
    output logic            o_valid,
    input  logic            i_ready,
    output logic            o_br_equal,
    output logic            o_br_less,
    output logic            o_busy
);

    localparam int c_NIBS = XLEN / 4;
    localparam int c_CW   = $clog2(c_NIBS);
    localparam logic [c_CW-1:0] c_LAST = c_CW'(c_NIBS - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [XLEN-1:0]   a_q, a_d;
    logic [XLEN-1:0]   bn_q, bn_d;
    logic              un_q, un_d;
    logic              msb_a_q, msb_a_d;
    logic              msb_b_q, msb_b_d;
    logic              carry_q, carry_d;
    logic              eq_acc_q, eq_acc_d;
    logic [c_CW-1:0]   cnt_q, cnt_d;
    logic              equal_q, equal_d;
    logic              less_q, less_d;

    logic [3:0]        w_nib_a, w_nib_b, w_g, w_p;
    logic              w_grp_g, w_grp_p, w_co, w_nib_eq;

    // CLA slice: only the group carry-out is consumed, the sum bits are never needed.
    always_comb begin
        w_nib_a  = a_q[int'(cnt_q)*4 +: 4];
        w_nib_b  = bn_q[int'(cnt_q)*4 +: 4];
        w_g      = w_nib_a & w_nib_b;
        w_p      = w_nib_a ^ w_nib_b;
        w_grp_g  = w_g[3]
                 | (w_p[3] & w_g[2])
                 | (w_p[3] & w_p[2] & w_g[1])
                 | (w_p[3] & w_p[2] & w_p[1] & w_g[0]);
        w_grp_p  = &w_p;
        w_co     = w_grp_g | (w_grp_p & carry_q);
        // A nibble equals the original B nibble exactly when it differs from ~B in every bit.
        w_nib_eq = w_grp_p;
    end

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        bn_d     = bn_q;
        un_d     = un_q;
        msb_a_d  = msb_a_q;
        msb_b_d  = msb_b_q;
        carry_d  = carry_q;
        eq_acc_d = eq_acc_q;
        cnt_d    = cnt_q;
        equal_d  = equal_q;
        less_d   = less_q;

        case (state_q)
            S_IDLE: begin
                if (!i_flush && i_valid) begin
                    a_d      = i_rs1_data;
                    bn_d     = ~i_rs2_data;
                    un_d     = i_br_un;
                    msb_a_d  = i_rs1_data[XLEN-1];
                    msb_b_d  = i_rs2_data[XLEN-1];
                    carry_d  = 1'b1;
                    eq_acc_d = 1'b1;
                    cnt_d    = '0;
                    state_d  = S_RUN;
                end
            end
            S_RUN: begin
                if (i_flush) begin
                    state_d = S_IDLE;
                end else begin
                    carry_d  = w_co;
                    eq_acc_d = eq_acc_q & w_nib_eq;
                    if (cnt_q == c_LAST) begin
                        state_d = S_DONE;
                        equal_d = eq_acc_q & w_nib_eq;
                        // Differing signs decide a signed compare without the subtraction.
                        if (!un_q && (msb_a_q != msb_b_q))
                            less_d = msb_a_q;
                        else
                            less_d = ~w_co;
                    end else begin
                        cnt_d = cnt_q + c_CW'(1);
                    end
                end
            end
            S_DONE: begin
                if (i_ready || i_flush) begin
                    state_d = S_IDLE;
                    equal_d = 1'b0;
                    less_d  = 1'b0;
                end
            end
            default: begin
                state_d = S_IDLE;
                equal_d = 1'b0;
                less_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q  <= S_IDLE;
            a_q      <= '0;
            bn_q     <= '0;
            un_q     <= 1'b0;
            msb_a_q  <= 1'b0;
            msb_b_q  <= 1'b0;
            carry_q  <= 1'b0;
            eq_acc_q <= 1'b0;
            cnt_q    <= '0;
            equal_q  <= 1'b0;
            less_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            bn_q     <= bn_d;
            un_q     <= un_d;
            msb_a_q  <= msb_a_d;
            msb_b_q  <= msb_b_d;
            carry_q  <= carry_d;
            eq_acc_q <= eq_acc_d;
            cnt_q    <= cnt_d;
            equal_q  <= equal_d;
            less_q   <= less_d;
        end
    end

    assign o_ready    = (state_q == S_IDLE);
    assign o_valid    = (state_q == S_DONE);
    assign o_busy     = (state_q != S_IDLE);
    assign o_br_equal = equal_q;
    assign o_br_less  = less_q;

endmodule

`default_nettype wire

// File: tb/tb_brc_nibble_seq.sv
// ============================================================================
// tb_brc_nibble_seq : directed and randomized checks of the nibble branch comparator
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_brc_nibble_seq;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_valid = 1'b0;
    logic        o_ready;
    logic [31:0] i_rs1_data = '0;
    logic [31:0] i_rs2_data = '0;
    logic        i_br_un = 1'b0;
    logic        i_flush = 1'b0;
    logic        o_valid;
    logic        i_ready = 1'b0;
    logic        o_br_equal;
    logic        o_br_less;
    logic        o_busy;

    int n_tests = 0;
    int n_fail  = 0;

    brc_nibble_seq #(.XLEN(32)) dut (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_valid    (i_valid),
        .o_ready    (o_ready),
        .i_rs1_data (i_rs1_data),
        .i_rs2_data (i_rs2_data),
        .i_br_un    (i_br_un),
        .i_flush    (i_flush),
        .o_valid    (o_valid),
        .i_ready    (i_ready),
        .o_br_equal (o_br_equal),
        .o_br_less  (o_br_less),
        .o_busy     (o_busy)
    );

    always #5 i_clk = ~i_clk;

    // All stimulus changes and samples happen on the falling edge.
    task automatic do_req(input logic [31:0] a, input logic [31:0] b, input logic un);
        i_valid    = 1'b1;
        i_rs1_data = a;
        i_rs2_data = b;
        i_br_un    = un;
        @(posedge i_clk);
        @(negedge i_clk);
        i_valid = 1'b0;
    endtask

    task automatic wait_done(output int lat, output bit timed_out);
        lat = 0;
        timed_out = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (o_valid) begin
                timed_out = 1'b0;
                break;
            end
            @(negedge i_clk);
            lat++;
        end
    endtask

    task automatic handshake();
        i_ready = 1'b1;
        @(posedge i_clk);
        @(negedge i_clk);
        i_ready = 1'b0;
    endtask

    task automatic run_cmp(input string name, input logic [31:0] a, input logic [31:0] b,
                           input logic un, input logic exp_eq, input logic exp_lt);
        int lat;
        bit to;
        do_req(a, b, un);
        wait_done(lat, to);
        n_tests++;
        if (to || lat != 8 || o_br_equal !== exp_eq || o_br_less !== exp_lt) begin
            n_fail++;
            $display("FAIL %s: timeout=%0d lat=%0d eq=%b lt=%b, required lat=8 eq=%b lt=%b",
                     name, to, lat, o_br_equal, o_br_less, exp_eq, exp_lt);
        end
        handshake();
    endtask

    task automatic test_reset();
        i_rst = 1'b1;
        repeat (2) @(negedge i_clk);
        n_tests++;
        if (o_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", o_ready); end
        n_tests++;
        if (o_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", o_valid); end
        n_tests++;
        if (o_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", o_busy); end
        n_tests++;
        if (o_br_equal !== 1'b0 || o_br_less !== 1'b0) begin
            n_fail++; $display("FAIL reset_flags: eq=%b lt=%b want 0 0", o_br_equal, o_br_less);
        end
        i_rst = 1'b0;
        @(negedge i_clk);
    endtask

    task automatic test_equal();
        run_cmp("eq_5_5", 32'h0000_0005, 32'h0000_0005, 1'b0, 1'b1, 1'b0);
        n_tests++;
        if (o_valid !== 1'b0 || o_ready !== 1'b1 || o_br_equal !== 1'b0 || o_br_less !== 1'b0) begin
            n_fail++;
            $display("FAIL post_handshake: valid=%b ready=%b eq=%b lt=%b want 0 1 0 0",
                     o_valid, o_ready, o_br_equal, o_br_less);
        end
    endtask

    task automatic test_sign_modes();
        run_cmp("ffff_vs_1_uns", 32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 1'b0, 1'b0);
        run_cmp("ffff_vs_1_sgn", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b1);
        run_cmp("min_vs_max_sgn", 32'h8000_0000, 32'h7FFF_FFFF, 1'b0, 1'b0, 1'b1);
        run_cmp("min_vs_max_uns", 32'h8000_0000, 32'h7FFF_FFFF, 1'b1, 1'b0, 1'b0);
        run_cmp("carry_chain_uns", 32'h0000_FFF0, 32'h0001_000F, 1'b1, 1'b0, 1'b1);
        run_cmp("gt_same_sign_sgn", 32'hFFFF_FFF0, 32'hFFFF_FF00, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_hold();
        int lat;
        bit to;
        int bad;
        do_req(32'h0000_0005, 32'h0000_0005, 1'b0);
        wait_done(lat, to);
        i_valid    = 1'b1;
        i_rs1_data = 32'h0000_0001;
        i_rs2_data = 32'h0000_0002;
        i_br_un    = 1'b1;
        bad = to ? 1 : 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge i_clk);
            if (o_valid !== 1'b1 || o_ready !== 1'b0 || o_br_equal !== 1'b1 || o_br_less !== 1'b0)
                bad++;
        end
        n_tests++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL hold_stable: %0d bad cycles, last valid=%b ready=%b eq=%b lt=%b want 1 0 1 0",
                     bad, o_valid, o_ready, o_br_equal, o_br_less);
        end
        i_valid = 1'b0;
        handshake();
        repeat (3) @(negedge i_clk);
        n_tests++;
        if (o_busy !== 1'b0 || o_valid !== 1'b0) begin
            n_fail++; $display("FAIL hold_no_capture: busy=%b valid=%b want 0 0", o_busy, o_valid);
        end
    endtask

    task automatic test_async_reset();
        do_req(32'h1234_5678, 32'h1234_5678, 1'b0);
        repeat (2) @(negedge i_clk);
        #2 i_rst = 1'b1;
        #1;
        n_tests++;
        if (o_busy !== 1'b0 || o_ready !== 1'b1 || o_valid !== 1'b0) begin
            n_fail++; $display("FAIL async_reset: busy=%b ready=%b valid=%b want 0 1 0",
                               o_busy, o_ready, o_valid);
        end
        @(negedge i_clk);
        i_rst = 1'b0;
        @(negedge i_clk);
        n_tests++;
        if (o_ready !== 1'b1) begin n_fail++; $display("FAIL reset_release_ready: got %b want 1", o_ready); end
        run_cmp("after_reset_3_7", 32'h0000_0003, 32'h0000_0007, 1'b1, 1'b0, 1'b1);
    endtask

    task automatic test_flush();
        int seen;
        do_req(32'h0000_0003, 32'h0000_0003, 1'b0);
        repeat (3) @(negedge i_clk);
        i_flush = 1'b1;
        @(posedge i_clk);
        @(negedge i_clk);
        i_flush = 1'b0;
        n_tests++;
        if (o_busy !== 1'b0 || o_ready !== 1'b1) begin
            n_fail++; $display("FAIL flush_run: busy=%b ready=%b want 0 1", o_busy, o_ready);
        end
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            if (o_valid) seen++;
            @(negedge i_clk);
        end
        n_tests++;
        if (seen != 0) begin n_fail++; $display("FAIL flush_no_valid: valid seen %0d cycles want 0", seen); end

        i_valid = 1'b1;
        i_flush = 1'b1;
        @(posedge i_clk);
        @(negedge i_clk);
        i_valid = 1'b0;
        i_flush = 1'b0;
        n_tests++;
        if (o_busy !== 1'b0) begin n_fail++; $display("FAIL flush_idle_priority: busy=%b want 0", o_busy); end

        do_req(32'h0000_0009, 32'h0000_0002, 1'b1);
        wait_done(seen, i_flush);
        i_ready = 1'b1;
        i_flush = 1'b1;
        @(posedge i_clk);
        @(negedge i_clk);
        i_ready = 1'b0;
        i_flush = 1'b0;
        n_tests++;
        if (o_busy !== 1'b0 || o_valid !== 1'b0 || o_br_equal !== 1'b0 || o_br_less !== 1'b0) begin
            n_fail++; $display("FAIL flush_ready_done: busy=%b valid=%b eq=%b lt=%b want 0 0 0 0",
                               o_busy, o_valid, o_br_equal, o_br_less);
        end
        run_cmp("after_flush_9_2", 32'h0000_0009, 32'h0000_0002, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_back_to_back();
        logic [31:0] a, b;
        logic        un, exp_eq, exp_lt;
        int          lat;
        bit          to;
        for (int n = 0; n < 1000; n++) begin
            a  = $urandom;
            un = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 3))
                0: b = $urandom;
                1: b = a;
                2: b = a ^ (32'h1 << $urandom_range(0, 31));
                default: b = {a[31:16], 16'($urandom_range(0, 65535))};
            endcase
            exp_eq = (a == b);
            exp_lt = un ? (a < b) : ($signed(a) < $signed(b));
            do_req(a, b, un);
            wait_done(lat, to);
            n_tests++;
            if (to || lat != 8 || o_br_equal !== exp_eq || o_br_less !== exp_lt) begin
                n_fail++;
                $display("FAIL rand[%0d] a=%h b=%h un=%b: to=%0d lat=%0d eq=%b lt=%b want eq=%b lt=%b",
                         n, a, b, un, to, lat, o_br_equal, o_br_less, exp_eq, exp_lt);
            end
            handshake();
        end
    endtask

    initial begin
        test_reset();
        test_equal();
        test_sign_modes();
        test_hold();
        test_async_reset();
        test_flush();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
